// File: rtl/bit_serial_pkg.sv
// Shared types and width-legality constants for the bit serialiser.
package bit_serial_pkg;

    localparam int unsigned MinWidth = 2;
    localparam int unsigned MaxWidth = 64;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    function automatic bit width_legal(input int unsigned w);
        return (w >= MinWidth) && (w <= MaxWidth);
    endfunction

endpackage

// File: rtl/mux_n.sv
// N-to-1 single-bit multiplexer; selects outside 0..N-1 yield 0.
module mux_n #(
    parameter int unsigned N    = 8,
    parameter int unsigned SelW = $clog2(N)
) (
    input  logic [N-1:0]    data_i,
    input  logic [SelW-1:0] sel_i,
    output logic            out_o
);

    always_comb begin
        out_o = 1'b0;
        if (32'(sel_i) < N) begin
            out_o = data_i[sel_i];
        end
    end

endmodule

// File: rtl/bit_serialiser.sv
// Parallel-to-serial converter with per-word MSB/LSB-first order and
// zero-bubble back-to-back word acceptance.
module bit_serialiser
    import bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data_par,
    input  logic             i_valid,
    input  logic             i_msb_first,
    output logic             o_ready,
    output logic             o_data_bit,
    output logic             o_bit_valid,
    input  logic             i_bit_ready,
    output logic             o_first,
    output logic             o_last
);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("bit_serialiser: WIDTH out of range");
    end

    localparam logic [CNT_W-1:0] IdxMax = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               msb_q, msb_d;

    logic               shifting;
    logic               word_hs;
    logic               bit_hs;
    logic               mux_bit;

    mux_n #(
        .N (WIDTH)
    ) u_mux (
        .data_i (word_q),
        .sel_i  (idx_q),
        .out_o  (mux_bit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            word_q  <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            msb_q   <= msb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        msb_d   = msb_q;
        // A new word wins over the last-bit retire so consecutive words abut.
        if (word_hs) begin
            state_d = StShift;
            word_d  = i_data_par;
            msb_d   = i_msb_first;
            idx_d   = i_msb_first ? IdxMax : '0;
        end else if (bit_hs) begin
            if (o_last) begin
                state_d = StIdle;
            end else if (msb_q) begin
                idx_d = idx_q - CNT_W'(1);
            end else begin
                idx_d = idx_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        shifting    = (state_q == StShift);
        o_bit_valid = shifting;
        o_data_bit  = shifting & mux_bit;
        o_first     = shifting && (msb_q ? (idx_q == IdxMax) : (idx_q == '0));
        o_last      = shifting && (msb_q ? (idx_q == '0) : (idx_q == IdxMax));
        o_ready     = !shifting || (o_last && i_bit_ready);
        word_hs     = i_valid && o_ready;
        bit_hs      = shifting && i_bit_ready;
    end

endmodule

// File: tb/tb_bit_serialiser.sv
// Directed vector bench for bit_serialiser at WIDTH=8 and WIDTH=5.
module tb_bit_serialiser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid, msb, br;
    logic [7:0] data;
    logic       ready, dbit, bv, first, last;

    logic       valid5, msb5, br5;
    logic [4:0] data5;
    logic       ready5, dbit5, bv5, first5, last5;

    bit_serialiser #(.WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data_par  (data),
        .i_valid     (valid),
        .i_msb_first (msb),
        .o_ready     (ready),
        .o_data_bit  (dbit),
        .o_bit_valid (bv),
        .i_bit_ready (br),
        .o_first     (first),
        .o_last      (last)
    );

    bit_serialiser #(.WIDTH(5)) dut5 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data_par  (data5),
        .i_valid     (valid5),
        .i_msb_first (msb5),
        .o_ready     (ready5),
        .o_data_bit  (dbit5),
        .o_bit_valid (bv5),
        .i_bit_ready (br5),
        .o_first     (first5),
        .o_last      (last5)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       m;
        logic       br;
        logic [4:0] exp;  // {ready, bit_valid, data_bit, first, last}
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic m, input logic b,
                                input logic [4:0] exp);
        vec_t e;
        e.v = v; e.d = d; e.m = m; e.br = b; e.exp = exp;
        vecs.push_back(e);
    endfunction

    function automatic void add_load(input logic [7:0] d, input logic m);
        add(1'b1, d, m, 1'b1, 5'b10000);
    endfunction

    // seq lists the expected bits in emission order, seq[7] first.
    function automatic void add_run(input logic [7:0] seq);
        for (int i = 0; i < 8; i++) begin
            add(1'b0, 8'h00, 1'b0, 1'b1,
                {(i == 7), 1'b1, seq[7-i], (i == 0), (i == 7)});
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s3c;
        logic [4:0] s5m, s5l;
        s3c = 8'b00111100;
        s5m = 5'b10110;
        s5l = 5'b01101;

        rst = 1'b1; valid = 0; msb = 0; br = 0; data = '0;
        valid5 = 0; msb5 = 0; br5 = 0; data5 = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #2;
        check("rst_ready", 0, ready, 1'b1);
        check("rst_bv", 0, bv, 1'b0);
        check("rst_bit", 0, dbit, 1'b0);
        check("rst_first", 0, first, 1'b0);
        check("rst_last", 0, last, 1'b0);
        check("rst5_ready", 0, ready5, 1'b1);
        check("rst5_bv", 0, bv5, 1'b0);

        // 0xA5 MSB-first, then LSB-first, then 0x01 LSB-first
        add_load(8'hA5, 1'b1); add_run(8'b10100101);
        add_load(8'hA5, 1'b0); add_run(8'b10100101);
        add_load(8'h01, 1'b0); add_run(8'b10000000);
        // 0xFF then 0x00 back-to-back; inputs wiggle mid-word
        add_load(8'hFF, 1'b1);
        for (int i = 0; i < 7; i++) add(1'b1, 8'h00, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, (i == 0), 1'b0});
        add(1'b1, 8'h00, 1'b1, 1'b1, 5'b11101);
        add_run(8'b00000000);
        // stall for 3 cycles after bit 3, then stall on the last bit
        add_load(8'hA5, 1'b1);
        add(0, 8'h00, 0, 1, 5'b01110);
        add(0, 8'h00, 0, 1, 5'b01000);
        add(0, 8'h00, 0, 1, 5'b01100);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0, 5'b01000);
        add(0, 8'h00, 0, 1, 5'b01000);
        add(0, 8'h00, 0, 1, 5'b01000);
        add(0, 8'h00, 0, 1, 5'b01100);
        add(0, 8'h00, 0, 1, 5'b01000);
        add(0, 8'h00, 0, 0, 5'b01101);
        add(0, 8'h00, 0, 1, 5'b11101);
        add(0, 8'h00, 0, 1, 5'b10000);

        foreach (vecs[k]) begin
            valid = vecs[k].v; data = vecs[k].d; msb = vecs[k].m; br = vecs[k].br;
            #2;
            check("ready", k, ready, vecs[k].exp[4]);
            check("bit_valid", k, bv, vecs[k].exp[3]);
            check("data_bit", k, dbit, vecs[k].exp[2]);
            check("first", k, first, vecs[k].exp[1]);
            check("last", k, last, vecs[k].exp[0]);
            next_cycle();
        end

        // reset after bit 5, with a competing word handshake in the reset cycle
        valid = 1; data = 8'hA5; msb = 1; br = 1;
        next_cycle();
        valid = 0;
        for (int i = 0; i < 5; i++) next_cycle();
        rst = 1; valid = 1; data = 8'hFF;
        next_cycle();
        rst = 0; valid = 0;
        #2;
        check("mid_rst_bv", 0, bv, 1'b0);
        check("mid_rst_ready", 0, ready, 1'b1);
        check("mid_rst_bit", 0, dbit, 1'b0);
        next_cycle();
        check("mid_rst_bv_hold", 1, bv, 1'b0);
        valid = 1; data = 8'h3C; msb = 1;
        next_cycle();
        valid = 0;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("w3c_bv", i, bv, 1'b1);
            check("w3c_bit", i, dbit, s3c[7-i]);
            check("w3c_first", i, first, i == 0);
            next_cycle();
        end
        check("w3c_done", 0, bv, 1'b0);

        // WIDTH=5, MSB-first then LSB-first
        valid5 = 1; data5 = 5'b10110; msb5 = 1; br5 = 1;
        next_cycle();
        valid5 = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("w5m_bit", i, dbit5, s5m[4-i]);
            check("w5m_last", i, last5, i == 4);
            check("w5m_ready", i, ready5, i == 4);
            next_cycle();
        end
        check("w5m_idle", 0, bv5, 1'b0);
        valid5 = 1; msb5 = 0;
        next_cycle();
        valid5 = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("w5l_bit", i, dbit5, s5l[4-i]);
            check("w5l_first", i, first5, i == 0);
            check("w5l_last", i, last5, i == 4);
            next_cycle();
        end
        check("w5l_idle", 0, bv5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bit_serialiser.md
BIT_SERIALISER -- requirements
Module: bit_serialiser

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), SHALL set the bit-index counter width; not overridden by instantiators.
REQ-003 Clocking and reset SHALL be as follows: one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  rising-edge clock for all state.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_data_par  input  WIDTH  parallel word to serialise.
REQ-007 i_valid  input  1  i_data_par and i_msb_first are valid.
REQ-008 i_msb_first  input  1  1 = emit bit WIDTH-1 first; 0 = emit bit 0 first; sampled with the word.
REQ-009 o_ready  output  1  block accepts a word this cycle.
REQ-010 o_data_bit  output  1  current serial bit.
REQ-011 o_bit_valid  output  1  o_data_bit is valid.
REQ-012 i_bit_ready  input  1  downstream consumes o_data_bit this cycle.
REQ-013 o_first  output  1  current bit is the first bit of its word.
REQ-014 o_last  output  1  current bit is the last bit of its word.

Function
REQ-015 The word handshake SHALL complete on a rising edge where i_valid && o_ready; the bit handshake SHALL complete on a rising edge where o_bit_valid && i_bit_ready.
REQ-016 States SHALL be IDLE (no word held) and SHIFT (word held, bits pending).
REQ-017 IDLE -> SHIFT on word handshake; SHIFT -> IDLE on bit handshake of the last bit with no word handshake in that cycle; SHIFT -> SHIFT otherwise.
REQ-018 On word handshake, the block SHALL register i_data_par and i_msb_first and load the bit index with WIDTH-1 (MSB-first) or 0 (LSB-first).
REQ-019 o_bit_valid SHALL be 1 exactly in SHIFT, asserting on the first cycle after the word handshake (1-cycle latency).
REQ-020 o_data_bit SHALL equal held_word[index], selected combinationally from registered state; 0 in IDLE.
REQ-021 On each bit handshake the index SHALL decrement (MSB-first) or increment (LSB-first) by one.
REQ-022 o_first SHALL be 1 in SHIFT when the index is at its load value; o_last SHALL be 1 in SHIFT when the index is 0 (MSB-first) or WIDTH-1 (LSB-first); both 0 in IDLE.
REQ-023 With i_bit_ready low, o_data_bit, o_first, o_last and the index SHALL hold unchanged.
REQ-024 o_ready SHALL be 1 in IDLE, and in SHIFT only when o_last && i_bit_ready (combinational path from i_bit_ready permitted).
REQ-025 Simultaneous last-bit handshake and word handshake SHALL load the new word and stay in SHIFT, giving zero idle cycles between words.
REQ-026 i_valid deasserting, or i_data_par/i_msb_first changing, mid-word SHALL NOT affect the word in flight.
REQ-027 The index SHALL never exceed WIDTH-1 and SHALL NOT wrap when WIDTH is not a power of two.

Reset
REQ-028 While i_rst is high at a rising edge: state -> IDLE, index -> 0, held word -> 0, held mode -> 0.
REQ-029 After reset, o_ready = 1 and o_bit_valid = o_data_bit = o_first = o_last = 0.
REQ-030 Reset asserted mid-word SHALL discard the remaining bits with no further o_bit_valid until a new word handshake.
REQ-031 Reset SHALL take priority over any handshake in the same cycle.

Structure
REQ-032 Package bit_serial_pkg SHALL hold the state enum (IDLE, SHIFT) and shared width-legality constants.
REQ-033 Bit selection SHALL be a sub-module mux_n (parameter N; select width $clog2(N); out-of-range select -> 0).
REQ-034 Sequential logic SHALL be a single always_ff; next-state and outputs in always_comb.

Verification
REQ-035 WIDTH=8, word 0xA5, MSB-first, i_bit_ready=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; o_first on bit 1, o_last on bit 8.
REQ-036 WIDTH=8, 0xA5, LSB-first -> bits 1,0,1,0,0,1,0,1 (LSB order); repeat 0x01 LSB-first -> 1,0,0,0,0,0,0,0.
REQ-037 Back-to-back 0xFF then 0x00, i_valid held high -> 16 contiguous valid bits (eight 1s then eight 0s); o_ready high only on the last-bit cycles.
REQ-038 i_bit_ready low for 3 cycles after bit 3 -> o_data_bit, o_first, o_last stable; resumes with bit 4; total 8 bits, none lost or repeated.
REQ-039 i_rst pulsed for 1 cycle after bit 5 -> o_bit_valid 0 on the next cycle; a new word 0x3C is then accepted and serialised from its first bit.
REQ-040 WIDTH=5, 5'b10110 MSB-first -> 1,0,1,1,0 with o_last on bit 5 and o_ready on that cycle; no index overrun.
